// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin arbiter: index width and one-hot to index encoding.
package arb_pkg;

    function automatic int arb_idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Assumes at most one bit set; a zero vector encodes to index 0.
    function automatic int unsigned arb_oh2idx(input logic [63:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr_gnt.sv
// Combinational rotating-priority grant: requests at or above ptr win, else wrap to the lowest.
module arb_rr_gnt
    import arb_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int SPLIT = 3
) (
    input  logic [WIDTH-1:0]            req_vld,
    input  logic [arb_idx_w(WIDTH)-1:0] ptr,
    output logic [WIDTH-1:0]            gnt
);

    localparam int NG = (WIDTH + SPLIT - 1) / SPLIT;
    localparam int PW = NG * SPLIT;

    // Two-level lowest-set-bit: first pick the lowest non-empty group, then the lowest bit inside it.
    function automatic logic [WIDTH-1:0] lsb_oh(input logic [WIDTH-1:0] x);
        logic [PW-1:0]    xp;
        logic [PW-1:0]    r;
        logic [NG-1:0]    grp_any;
        logic [NG-1:0]    grp_sel;
        logic [SPLIT-1:0] sub;
        xp = PW'(x);
        r  = '0;
        for (int g = 0; g < NG; g++) begin
            grp_any[g] = |xp[g*SPLIT +: SPLIT];
        end
        grp_sel = grp_any & (~grp_any + NG'(1));
        for (int g = 0; g < NG; g++) begin
            sub = xp[g*SPLIT +: SPLIT];
            if (grp_sel[g]) r[g*SPLIT +: SPLIT] = sub & (~sub + SPLIT'(1));
        end
        return r[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] msk;
    logic [WIDTH-1:0] gnt_msk;
    logic [WIDTH-1:0] gnt_raw;

    always_comb begin
        msk     = req_vld & ({WIDTH{1'b1}} << ptr);
        gnt_msk = lsb_oh(msk);
        gnt_raw = lsb_oh(req_vld);
        gnt     = (|msk) ? gnt_msk : gnt_raw;
    end

endmodule

// File: rtl/mux_pry.sv
// One-hot priority multiplexer: the lowest set select bit picks its data word.
module mux_pry #(
    parameter type DAT_T          = logic [7:0],
    parameter int  WIDTH          = 9,
    parameter int  SPLIT          = 3,
    parameter int  IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] sel,
    input  DAT_T [WIDTH-1:0] dat,
    output DAT_T             out
);

    if (IMPLEMENTATION == 0) begin : g_scan
        always_comb begin
            out = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (sel[i]) out = dat[i];
            end
        end
    end else begin : g_tree
        // AND-OR tree in SPLIT-wide groups; only valid for a one-hot select.
        localparam int NG = (WIDTH + SPLIT - 1) / SPLIT;
        DAT_T [NG-1:0] grp;
        always_comb begin
            grp = '0;
            out = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (sel[i]) grp[i / SPLIT] = grp[i / SPLIT] | dat[i];
            end
            for (int g = 0; g < NG; g++) begin
                out = out | grp[g];
            end
        end
    end

endmodule

// File: rtl/arb_rr_mux.sv
// Round-robin arbiter with registered output stage sharing one valid/ready channel.
// Optional ARB_RR_MUX_LOCK_EN adds req_lck so a locked winner keeps top priority.
module arb_rr_mux
    import arb_pkg::*;
#(
    parameter type DAT_T          = logic [8-1:0],
    parameter int  WIDTH          = 9,
    parameter int  SPLIT          = 3,
    parameter int  IMPLEMENTATION = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            req_vld,
    input  DAT_T [WIDTH-1:0]            req_dat,
    output logic [WIDTH-1:0]            req_rdy,
`ifdef ARB_RR_MUX_LOCK_EN
    input  logic [WIDTH-1:0]            req_lck,
`endif
    output logic                        out_vld,
    output DAT_T                        out_dat,
    output logic [arb_idx_w(WIDTH)-1:0] out_idx,
    input  logic                        out_rdy
);

    localparam int IW = arb_idx_w(WIDTH);

    logic             out_vld_q, out_vld_d;
    DAT_T             out_dat_q, out_dat_d;
    logic [IW-1:0]    out_idx_q, out_idx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] gnt;
    DAT_T             sel_dat;
    logic             ld;
    logic             xfer;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    ptr_nxt;

    arb_rr_gnt #(
        .WIDTH (WIDTH),
        .SPLIT (SPLIT)
    ) u_gnt (
        .req_vld (req_vld),
        .ptr     (ptr_q),
        .gnt     (gnt)
    );

    // Grant is one-hot, so the mux's lowest-index priority needs no reordering.
    mux_pry #(
        .DAT_T          (DAT_T),
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_mux (
        .sel (gnt),
        .dat (req_dat),
        .out (sel_dat)
    );

    always_comb begin
        ld        = ~out_vld_q | out_rdy;
        req_rdy   = (ld & ~rst) ? gnt : '0;
        xfer      = |req_rdy;
        gnt_idx   = IW'(arb_oh2idx(64'(gnt)));
        ptr_nxt   = (gnt_idx == IW'(WIDTH - 1)) ? '0 : gnt_idx + IW'(1);
`ifdef ARB_RR_MUX_LOCK_EN
        if (|(req_lck & gnt)) ptr_nxt = gnt_idx;
`endif
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_idx_d = out_idx_q;
        ptr_d     = ptr_q;
        if (ld) begin
            if (xfer) begin
                out_vld_d = 1'b1;
                out_dat_d = sel_dat;
                out_idx_d = gnt_idx;
                ptr_d     = ptr_nxt;
            end else begin
                out_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_idx_q <= '0;
            ptr_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_idx_q <= out_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_vld = out_vld_q;
    assign out_dat = out_dat_q;
    assign out_idx = out_idx_q;

endmodule

// File: tb/tb_arb_rr_mux.sv
// Directed testbench for arb_rr_mux with WIDTH=4 and payload 8'hA0+i.
module tb_arb_rr_mux;

    logic            clk;
    logic            rst;
    logic [3:0]      req_vld;
    logic [3:0][7:0] req_dat;
    logic [3:0]      req_rdy;
`ifdef ARB_RR_MUX_LOCK_EN
    logic [3:0]      req_lck;
`endif
    logic            out_vld;
    logic [7:0]      out_dat;
    logic [1:0]      out_idx;
    logic            out_rdy;

    int checks = 0;
    int errors = 0;

    arb_rr_mux #(
        .DAT_T          (logic [7:0]),
        .WIDTH          (4),
        .SPLIT          (3),
        .IMPLEMENTATION (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_dat (req_dat),
        .req_rdy (req_rdy),
`ifdef ARB_RR_MUX_LOCK_EN
        .req_lck (req_lck),
`endif
        .out_vld (out_vld),
        .out_dat (out_dat),
        .out_idx (out_idx),
        .out_rdy (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [1:0] idx);
        chk({tag, "_vld"}, 32'(out_vld), 32'd1);
        chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
        chk({tag, "_dat"}, 32'(out_dat), 32'(8'hA0 + 8'(idx)));
    endtask

    initial begin
        logic [1:0] seq_a [5];
        logic [1:0] seq_l [6];
        seq_a = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3};
        seq_l = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) req_dat[i] = 8'hA0 + 8'(i);
        rst = 1'b1;
        req_vld = 4'h0;
        out_rdy = 1'b1;
`ifdef ARB_RR_MUX_LOCK_EN
        req_lck = 4'h0;
`endif
        tick();
        // Requests during reset must not be accepted.
        req_vld = 4'hF;
        #1;
        chk("rst_rdy", 32'(req_rdy), 32'h0);
        tick();
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_dat", 32'(out_dat), 32'h0);

        // Idle for 5 cycles.
        rst = 1'b0;
        req_vld = 4'h0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("idle_rdy", 32'(req_rdy), 32'h0);
            tick();
            chk("idle_vld", 32'(out_vld), 32'd0);
            chk("idle_idx", 32'(out_idx), 32'd0);
        end

        // All requesting: strict rotation 0,1,2,3,0,1,2,3.
        req_vld = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("all_rdy", 32'(req_rdy), 32'(4'b0001 << (k % 4)));
            tick();
            chk_word("all", 2'(k % 4));
        end

        // Bring ptr to 2 (grants 0 then 1), then 1010 alternates 3,1,3.
        for (int k = 0; k < 5; k++) begin
            req_vld = (k < 2) ? 4'b0011 : 4'b1010;
            tick();
            chk_word("rot", seq_a[k]);
        end

        // Load A1 (ptr 0 -> 2), then hold it under backpressure.
        req_vld = 4'b0010;
        tick();
        chk_word("bp_load", 2'd1);
        out_rdy = 1'b0;
        req_vld = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_rdy", 32'(req_rdy), 32'h0);
            tick();
            chk_word("bp_hold", 2'd1);
        end
        // Release: A1 drains and requester 2 loads in the same edge.
        out_rdy = 1'b1;
        #1;
        chk("rel_rdy", 32'(req_rdy), 32'b0100);
        tick();
        chk_word("rel", 2'd2);

        // No request with ld high: valid drops, index and data hold.
        req_vld = 4'h0;
        tick();
        chk("drain_vld", 32'(out_vld), 32'd0);
        chk("drain_idx", 32'(out_idx), 32'd2);
        chk("drain_dat", 32'(out_dat), 32'hA2);

        // ptr is 3; only requester 2 asks, so the grant wraps to it and ptr stays 3.
        req_vld = 4'b0100;
        tick();
        chk_word("wrap", 2'd2);

        // Reset with a pending word: dropped, ptr back to 0.
        rst = 1'b1;
        req_vld = 4'hF;
        #1;
        chk("mid_rst_rdy", 32'(req_rdy), 32'h0);
        tick();
        chk("mid_rst_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_idx", 32'(out_idx), 32'd0);
        rst = 1'b0;
        req_vld = 4'b1001;
        #1;
        chk("post_rst_rdy", 32'(req_rdy), 32'b0001);
        tick();
        chk_word("post_rst", 2'd0);

`ifdef ARB_RR_MUX_LOCK_EN
        // ptr is 1; lock held on the first two accepted words of requester 1.
        req_vld = 4'hF;
        for (int k = 0; k < 6; k++) begin
            req_lck = (k < 2) ? 4'b0010 : 4'b0000;
            tick();
            chk_word("lck", seq_l[k]);
        end
        req_lck = 4'h0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
